// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART frame sequencer: state encoding, framing bytes, ALU strobe bits.
package uart_alu_pkg;

   typedef enum logic [3:0] {
      StGetA    = 4'd0,
      StGetB    = 4'd1,
      StGetOp   = 4'd2,
      StGetTerm = 4'd3,
      StLoadA   = 4'd4,
      StLoadB   = 4'd5,
      StLoadOp  = 4'd6,
      StWaitAlu = 4'd7,
      StSendHi  = 4'd8,
      StSendLo  = 4'd9,
      StSendCr  = 4'd10
   } state_e;

   localparam logic [7:0] CR         = 8'h0D;
   localparam logic [7:0] ASCII_ZERO = 8'h30;
   // 'A' minus 10, so nibble values 10..15 map onto 'A'..'F'
   localparam logic [7:0] ASCII_HEX  = 8'h37;

   localparam int unsigned SEL_A  = 0;
   localparam int unsigned SEL_B  = 1;
   localparam int unsigned SEL_OP = 2;

   function automatic logic is_dec_digit(input logic [7:0] ch);
      return (ch >= 8'h30) && (ch <= 8'h39);
   endfunction

endpackage

// File: rtl/uart_alu_ctrl_nib2ascii.sv
// Combinational 4-bit to uppercase ASCII hex character converter.
module nib2ascii
   import uart_alu_pkg::*;
(
   input  logic [3:0] nib,
   output logic [7:0] ascii
);

   always_comb begin
      if (nib < 4'd10) begin
         ascii = ASCII_ZERO + {4'b0000, nib};
      end else begin
         ascii = ASCII_HEX + {4'b0000, nib};
      end
   end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frame sequencer: RX FIFO -> ALU operand loads -> TX FIFO.
// UART_ALU_ASCII_EN selects ASCII-decimal operands and hex-ASCII result output.
module uart_alu_ctrl
   import uart_alu_pkg::*;
#(
   parameter int unsigned ALU_LAT = 2
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       rx_empty,
   input  logic [7:0] rx_data,
   output logic       rd_rx,
   output logic [7:0] alu_data,
   output logic [2:0] alu_sel,
   input  logic [7:0] alu_result,
   input  logic       tx_full,
   output logic [7:0] tx_data,
   output logic       wr_tx,
   output logic       busy,
   output logic       err,
   output logic [3:0] state
);

   state_e     state_q, state_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [7:0] op_q, op_d;
   logic [7:0] res_q, res_d;
   logic [3:0] cnt_q, cnt_d;

`ifdef UART_ALU_ASCII_EN
   logic [7:0] hi_char;
   logic [7:0] lo_char;

   nib2ascii u_hi (
      .nib   (res_q[7:4]),
      .ascii (hi_char)
   );

   nib2ascii u_lo (
      .nib   (res_q[3:0]),
      .ascii (lo_char)
   );
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= StGetA;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         op_q    <= 8'h00;
         res_q   <= 8'h00;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      res_d    = res_q;
      cnt_d    = cnt_q;
      rd_rx    = 1'b0;
      wr_tx    = 1'b0;
      alu_sel  = 3'b000;
      alu_data = 8'h00;
      tx_data  = 8'h00;
      err      = 1'b0;

      unique case (state_q)
         StGetA: begin
            if (!rx_empty) begin
               rd_rx = 1'b1;
`ifdef UART_ALU_ASCII_EN
               if (is_dec_digit(rx_data)) begin
                  a_d     = rx_data - ASCII_ZERO;
                  state_d = StGetB;
               end else begin
                  err = 1'b1;
               end
`else
               a_d     = rx_data;
               state_d = StGetB;
`endif
            end
         end
         StGetB: begin
            if (!rx_empty) begin
               rd_rx = 1'b1;
`ifdef UART_ALU_ASCII_EN
               if (is_dec_digit(rx_data)) begin
                  b_d     = rx_data - ASCII_ZERO;
                  state_d = StGetOp;
               end else begin
                  err     = 1'b1;
                  state_d = StGetA;
               end
`else
               b_d     = rx_data;
               state_d = StGetOp;
`endif
            end
         end
         StGetOp: begin
            if (!rx_empty) begin
               rd_rx   = 1'b1;
               op_d    = rx_data;
               state_d = StGetTerm;
            end
         end
         StGetTerm: begin
            // The terminator is consumed whatever its value; a bad one drops the frame.
            if (!rx_empty) begin
               rd_rx = 1'b1;
               if (rx_data == CR) begin
                  state_d = StLoadA;
               end else begin
                  err     = 1'b1;
                  state_d = StGetA;
               end
            end
         end
         StLoadA: begin
            alu_sel[SEL_A] = 1'b1;
            alu_data       = a_q;
            state_d        = StLoadB;
         end
         StLoadB: begin
            alu_sel[SEL_B] = 1'b1;
            alu_data       = b_q;
            state_d        = StLoadOp;
         end
         StLoadOp: begin
            alu_sel[SEL_OP] = 1'b1;
            alu_data        = op_q;
            cnt_d           = 4'd0;
            state_d         = StWaitAlu;
         end
         StWaitAlu: begin
            if (cnt_q == 4'(ALU_LAT - 1)) begin
               res_d = alu_result;
`ifdef UART_ALU_ASCII_EN
               state_d = StSendHi;
`else
               state_d = StSendLo;
`endif
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StSendHi: begin
`ifdef UART_ALU_ASCII_EN
            if (!tx_full) begin
               wr_tx   = 1'b1;
               tx_data = hi_char;
               state_d = StSendLo;
            end
`else
            state_d = StSendLo;
`endif
         end
         StSendLo: begin
            if (!tx_full) begin
               wr_tx = 1'b1;
`ifdef UART_ALU_ASCII_EN
               tx_data = lo_char;
`else
               tx_data = res_q;
`endif
               state_d = StSendCr;
            end
         end
         StSendCr: begin
            if (!tx_full) begin
               wr_tx   = 1'b1;
               tx_data = CR;
               state_d = StGetA;
            end
         end
         default: state_d = StGetA;
      endcase

      // Reset aborts at once: nothing may be popped, strobed or written in the reset cycle.
      if (RESET) begin
         rd_rx    = 1'b0;
         wr_tx    = 1'b0;
         alu_sel  = 3'b000;
         alu_data = 8'h00;
         tx_data  = 8'h00;
         err      = 1'b0;
      end
   end

   assign busy  = (state_q != StGetA);
   assign state = state_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl with RX/TX FIFO models and a fixed-latency ALU model.
module tb_uart_alu_ctrl;

   localparam int unsigned ALU_LAT = 2;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       rx_empty;
   logic [7:0] rx_data;
   logic       rd_rx;
   logic [7:0] alu_data;
   logic [2:0] alu_sel;
   logic [7:0] alu_result;
   logic       tx_full;
   logic [7:0] tx_data;
   logic       wr_tx;
   logic       busy;
   logic       err;
   logic [3:0] state;

   uart_alu_ctrl #(.ALU_LAT(ALU_LAT)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .rx_empty   (rx_empty),
      .rx_data    (rx_data),
      .rd_rx      (rd_rx),
      .alu_data   (alu_data),
      .alu_sel    (alu_sel),
      .alu_result (alu_result),
      .tx_full    (tx_full),
      .tx_data    (tx_data),
      .wr_tx      (wr_tx),
      .busy       (busy),
      .err        (err),
      .state      (state)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  rxq[$];
   logic [7:0]  tx_log[$];
   logic [10:0] sel_log[$];
   int rd_cnt = 0, err_cnt = 0, wr_full_cnt = 0, both_cnt = 0, cyc = 0;
   int cr_pop_cyc = -1, first_wr_cyc = -1;
   logic       pend_rd = 1'b0;
   logic [2:0] pend_sel = 3'b000;
   logic [7:0] pend_data = 8'h00;
   logic [7:0] alu_a = 8'h00, alu_b = 8'h00, alu_op = 8'h00;
   int lat = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic void rx_refresh();
      rx_empty = (rxq.size() == 0);
      rx_data  = rx_empty ? 8'h00 : rxq[0];
   endfunction

   // ALU model: 0x20 add, 0x22 subtract; result only valid ALU_LAT cycles after the OP strobe.
   function automatic void alu_refresh();
      logic [7:0] f;
      case (alu_op)
         8'h20:   f = alu_a + alu_b;
         8'h22:   f = alu_a - alu_b;
         default: f = 8'hFF;
      endcase
      alu_result = (lat >= int'(ALU_LAT)) ? f : 8'hEE;
   endfunction

   always @(negedge CLK) begin
      if (rd_rx) begin
         pend_rd = 1'b1;
         rd_cnt++;
         if (state == 4'd3 && rx_data == 8'h0D) cr_pop_cyc = cyc;
      end
      if (wr_tx) begin
         tx_log.push_back(tx_data);
         if (first_wr_cyc < 0) first_wr_cyc = cyc;
         if (tx_full) wr_full_cnt++;
      end
      if (alu_sel != 3'b000) begin
         sel_log.push_back({alu_sel, alu_data});
         pend_sel  = alu_sel;
         pend_data = alu_data;
      end
      if (err) err_cnt++;
      if (rd_rx && wr_tx) both_cnt++;
   end

   always @(posedge CLK) begin
      cyc++;
      #1;
      if (pend_rd && rxq.size() > 0) void'(rxq.pop_front());
      pend_rd = 1'b0;
      case (pend_sel)
         3'b001:  alu_a  = pend_data;
         3'b010:  alu_b  = pend_data;
         3'b100:  alu_op = pend_data;
         default: ;
      endcase
      if (pend_sel == 3'b100) lat = 1;
      else if (lat > 0 && lat < 100) lat++;
      pend_sel = 3'b000;
      rx_refresh();
      alu_refresh();
   end

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic clear_logs();
      tx_log.delete();
      sel_log.delete();
      rd_cnt       = 0;
      err_cnt      = 0;
      cr_pop_cyc   = -1;
      first_wr_cyc = -1;
   endtask

   task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
      rxq.push_back(b0);
      rxq.push_back(b1);
      rxq.push_back(b2);
      rxq.push_back(b3);
      rx_refresh();
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      tick();
      while (!(rxq.size() == 0 && state == 4'd0 && !busy) && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_done"}, 32'(n < budget), 32'd1);
      tick();
      tick();
   endtask

   task automatic wait_state(input string tag, input logic [3:0] st, input int budget);
      int n = 0;
      while (state != st && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_reach"}, 32'(state == st), 32'd1);
   endtask

   task automatic check_tx(input string tag, input int n, input logic [7:0] e0,
                           input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
      logic [7:0] e[4];
      e[0] = e0;
      e[1] = e1;
      e[2] = e2;
      e[3] = e3;
      check({tag, "_tx_n"}, 32'(tx_log.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (i < tx_log.size()) check($sformatf("%s_tx%0d", tag, i), 32'(tx_log[i]), 32'(e[i]));
      end
   endtask

   task automatic check_sel(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op);
      logic [10:0] e[3];
      e[0] = {3'b001, a};
      e[1] = {3'b010, b};
      e[2] = {3'b100, op};
      check({tag, "_sel_n"}, 32'(sel_log.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < sel_log.size()) check($sformatf("%s_sel%0d", tag, i), 32'(sel_log[i]), 32'(e[i]));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"}, 32'(state), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_rd_rx"}, 32'(rd_rx), 32'd0);
      check({tag, "_wr_tx"}, 32'(wr_tx), 32'd0);
      check({tag, "_alu_sel"}, 32'(alu_sel), 32'd0);
      check({tag, "_alu_data"}, 32'(alu_data), 32'd0);
      check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      int stuck;
      int rd_before;
      RESET   = 1'b1;
      tx_full = 1'b0;
      rx_refresh();
      alu_refresh();
      repeat (3) tick();
      RESET = 1'b0;
      tick();
      check_reset_outputs("rst");

`ifdef UART_ALU_ASCII_EN
      clear_logs();
      push_frame(8'h37, 8'h35, 8'h20, 8'h0D);
      wait_idle("asc1", 60);
      check_sel("asc1", 8'h07, 8'h05, 8'h20);
      check_tx("asc1", 3, 8'h30, 8'h43, 8'h0D, 8'h00);
      check("asc1_err", 32'(err_cnt), 32'd0);
      check("asc1_lat", 32'(first_wr_cyc - cr_pop_cyc), 32'(3 + ALU_LAT + 1));

      clear_logs();
      rxq.push_back(8'h41);
      push_frame(8'h37, 8'h35, 8'h20, 8'h0D);
      wait_idle("asc2", 80);
      check("asc2_err", 32'(err_cnt), 32'd1);
      check("asc2_pops", 32'(rd_cnt), 32'd5);
      check_sel("asc2", 8'h07, 8'h05, 8'h20);
      check_tx("asc2", 3, 8'h30, 8'h43, 8'h0D, 8'h00);
`else
      // Basic ADD frame
      clear_logs();
      push_frame(8'h07, 8'h05, 8'h20, 8'h0D);
      wait_idle("add", 60);
      check_sel("add", 8'h07, 8'h05, 8'h20);
      check_tx("add", 2, 8'h0C, 8'h0D, 8'h00, 8'h00);
      check("add_err", 32'(err_cnt), 32'd0);
      check("add_pops", 32'(rd_cnt), 32'd4);
      check("add_lat", 32'(first_wr_cyc - cr_pop_cyc), 32'(3 + ALU_LAT + 1));

      // Bad terminator drops the frame
      clear_logs();
      push_frame(8'h07, 8'h05, 8'h20, 8'h41);
      wait_idle("badterm", 40);
      check("badterm_pops", 32'(rd_cnt), 32'd4);
      check("badterm_err", 32'(err_cnt), 32'd1);
      check("badterm_sel_n", 32'(sel_log.size()), 32'd0);
      check("badterm_tx_n", 32'(tx_log.size()), 32'd0);

      clear_logs();
      push_frame(8'h09, 8'h03, 8'h22, 8'h0D);
      wait_idle("sub", 60);
      check_sel("sub", 8'h09, 8'h03, 8'h22);
      check_tx("sub", 2, 8'h06, 8'h0D, 8'h00, 8'h00);
      check("sub_err", 32'(err_cnt), 32'd0);

      // TX back-pressure while the next frame waits in the RX FIFO
      clear_logs();
      tx_full = 1'b1;
      push_frame(8'h0A, 8'h01, 8'h20, 8'h0D);
      wait_state("stall", 4'd9, 40);
      push_frame(8'h09, 8'h03, 8'h22, 8'h0D);
      rd_before = rd_cnt;
      stuck = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (state != 4'd9) stuck++;
      end
      check("stall_hold", 32'(stuck), 32'd0);
      check("stall_no_wr", 32'(tx_log.size()), 32'd0);
      check("stall_no_pop", 32'(rd_cnt), 32'(rd_before));
      tx_full = 1'b0;
      wait_idle("stall", 80);
      check_tx("stall", 4, 8'h0B, 8'h0D, 8'h06, 8'h0D);
      check("stall_wr_full", 32'(wr_full_cnt), 32'd0);

      // Reset in the middle of WAIT_ALU
      clear_logs();
      push_frame(8'h0A, 8'h01, 8'h20, 8'h0D);
      wait_state("rstw", 4'd7, 40);
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      check_reset_outputs("rstw");
      repeat (15) tick();
      check("rstw_no_tx", 32'(tx_log.size()), 32'd0);
      check("rstw_state", 32'(state), 32'd0);

      clear_logs();
      push_frame(8'h09, 8'h03, 8'h22, 8'h0D);
      wait_idle("post", 60);
      check_tx("post", 2, 8'h06, 8'h0D, 8'h00, 8'h00);
`endif

      check("both_fifos", 32'(both_cnt), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Frame sequencer between the UART receive FIFO, the ALU operand registers and the UART transmit FIFO. Pops a 4-byte command frame (A, B, OP, CR) from the RX FIFO and loads A, B and OP into the ALU with one-cycle select strobes. Waits a fixed ALU latency, then pushes the result plus CR into the TX FIFO. Malformed frames are discarded and flagged.

## Interface
- ALU_LAT, 2: cycles from the OP load strobe to a valid `alu_result` (1..15).
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- rx_empty  in  1  RX FIFO empty; `rx_data` is valid whenever low (first-word-fall-through).
- rx_data  in  8  RX FIFO head byte.
- rd_rx  out  1  pop RX FIFO; one-cycle pulse.
- alu_data  out  8  operand/opcode bus to the ALU registers.
- alu_sel  out  3  one-hot load strobe: bit0 A, bit1 B, bit2 OP.
- alu_result  in  8  ALU output.
- tx_full  in  1  TX FIFO full.
- tx_data  out  8  byte to TX FIFO.
- wr_tx  out  1  push TX FIFO; one-cycle pulse.
- busy  out  1  high in every state except GET_A.
- err  out  1  one-cycle pulse on frame discard.
- state  out  4  current state encoding, for debug.

## Operation
- States: GET_A, GET_B, GET_OP, GET_TERM, LOAD_A, LOAD_B, LOAD_OP, WAIT_ALU, SEND_HI, SEND_LO, SEND_CR.
- GET_*: while `rx_empty`=0, assert `rd_rx` and latch `rx_data` on the same edge, then advance. While `rx_empty`=1, hold with no pop.
- GET_TERM: the byte is popped regardless of value. 0x0D advances to LOAD_A. Any other value pulses `err` and returns to GET_A; the frame is dropped and no ALU strobe is issued.
- LOAD_A/B/OP: one cycle each. Drive the latched byte on `alu_data` with the matching `alu_sel` bit; `alu_sel` is 0 in all other states.
- WAIT_ALU: counts ALU_LAT cycles, then captures `alu_result` into the result register.
- SEND_*: assert `wr_tx` with `tx_data` only when `tx_full`=0; otherwise stall in the state with `wr_tx`=0.
- SEND_CR sends 0x0D and returns to GET_A.
- Only one frame is in flight; RX bytes are not popped during LOAD/WAIT/SEND.

## Timing
- Reset values: state=GET_A, rd_rx=0, wr_tx=0, alu_sel=0, alu_data=0, tx_data=0, err=0, busy=0, all internal registers 0.
- RESET asserted mid-frame aborts immediately. No partial strobe or write follows, and half-received bytes are lost.
- `rd_rx`, `wr_tx`, `alu_sel`, `err` are registered-state decodes and never assert for more than one cycle per byte or strobe.
- Minimum frame-to-first-TX-write latency, measured from the edge popping CR: 3 (LOAD) + ALU_LAT + 1 cycles.
- If `rx_empty` and `tx_full` deassert in the same cycle, the state alone decides which FIFO is serviced. No state drives both.
- `tx_full` rising in the same cycle as a write is ignored; the decision uses the sampled value.

## Configuration
- `UART_ALU_ASCII_EN` defined:
  - A and B must be ASCII '0'..'9' (0x30..0x39) and are converted by subtracting 0x30. Any other value pulses `err` at pop time and returns to GET_A.
  - OP passes raw.
  - The result is sent as two uppercase hex ASCII characters (SEND_HI, SEND_LO), then CR.
- Undefined:
  - A and B pass raw with no range check.
  - SEND_HI is skipped; SEND_LO sends the raw result byte, then CR.

## Structure
- Shared package `uart_alu_pkg`:
  - state enumeration
  - CR constant 0x0D
  - ASCII '0' offset 0x30
  - `alu_sel` bit indices
- Sub-module `nib2ascii`: 4-bit to ASCII hex, combinational; instantiated twice under the macro.

## Test plan
- Raw build, ALU_LAT=2, bench ALU with 0x20=ADD and 0x22=SUB. Frame 0x07,0x05,0x20,0x0D -> alu_sel pulses 001/010/100 with 0x07/0x05/0x20; TX receives 0x0C, 0x0D; err never asserts.
- Same frame with the terminator replaced by 0x41 -> 4 pops, err pulse, no alu_sel activity, no wr_tx. A following valid frame 0x09,0x03,0x22,0x0D yields TX 0x06, 0x0D.
- ASCII build: '7','5',0x20,CR (0x37,0x35,0x20,0x0D) -> ALU loads 0x07, 0x05; TX receives 0x30,0x43,0x0D ("0C\r").
- ASCII build: A=0x41 -> err on that pop, state returns to GET_A, and the remaining bytes are parsed as a new frame.
- Hold tx_full=1 for 10 cycles during SEND_LO -> wr_tx stays 0 and state holds. After release, exactly one write per byte with no duplicates.
- Assert RESET for 1 cycle during WAIT_ALU -> all outputs return to reset values and no TX write follows; the next frame processes normally.
